rst_seq_release: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_sync_n.sv | 24 ++
 rtl/rst_seq_release.sv | 195 +++++++++++++++++++
 tb/tb_rst_seq_release.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the staggered reset-release sequencer.
package rst_seq_pkg;

    // Sequencer states; the encoding is exported on state_o for debug.
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAIL    = 3'd4
    } state_e;

    localparam int unsigned DATA_W_DEFAULT   = 24;
    localparam logic [23:0] EXPECTED_DEFAULT = 24'hC0FFEE;

endpackage : rst_seq_pkg

// File: rtl/rst_sync_n.sv
// Reset synchronizer: asserts asynchronously with rst_n, deasserts after
// SYNC_STAGES clock edges so downstream logic sees a clean release.
module rst_sync_n #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift a one in after rst_n rises; clear the whole chain on assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule : rst_sync_n

// File: rtl/rst_seq_release.sv
// Staggered domain reset release with post-release result check.
// Optional build macro: RST_SEQ_ZERO_CHECK_EN -- while domain 0 is still in
// reset the result word must read zero, otherwise the sequence ends in FAIL.
module rst_seq_release
    import rst_seq_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES    = 2,
    parameter int unsigned       NUM_DOMAINS    = 3,
    parameter int unsigned       STAGGER_CYCLES = 16,
    parameter int unsigned       DATA_W         = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] EXPECTED       = DATA_W'(EXPECTED_DEFAULT),
    parameter int unsigned       CHECK_TIMEOUT  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst_req,
    input  logic [DATA_W-1:0]      result_in,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   ready,
    output logic                   check_fail,
    output logic [2:0]             state_o
);

    localparam int unsigned CNT_W  = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int unsigned IDX_W  = (NUM_DOMAINS > 1)    ? $clog2(NUM_DOMAINS)    : 1;
    localparam int unsigned TCNT_W = (CHECK_TIMEOUT > 1)  ? $clog2(CHECK_TIMEOUT)  : 1;

    logic                   rst_synced_n;
    logic                   zero_fail_c;

    state_e                 state_q,      state_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [IDX_W-1:0]       idx_q,        idx_d;
    logic [TCNT_W-1:0]      tcnt_q,       tcnt_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q,    dom_rst_d;
    logic                   ready_q,      ready_d;
    logic                   check_fail_q, check_fail_d;

    rst_sync_n #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .rst_sync_n  (rst_synced_n)
    );

`ifdef RST_SEQ_ZERO_CHECK_EN
    logic zero_err_q, zero_err_d;
    logic zero_now_c;

    assign zero_now_c  = (state_q == ST_RELEASE) && dom_rst_q[0] && (result_in != '0);
    assign zero_fail_c = zero_err_q | zero_now_c;

    // Remember any nonzero sample seen during the current release pass.
    always_comb begin
        zero_err_d = 1'b0;
        if (state_q == ST_RELEASE) begin
            zero_err_d = zero_err_q | zero_now_c;
        end
    end

    // Zero-check error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_err_q <= 1'b0;
        end else begin
            zero_err_q <= zero_err_d;
        end
    end
`else
    assign zero_fail_c = 1'b0;
`endif

    // State and datapath registers; rst_n aborts any sequence in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            idx_q        <= '0;
            tcnt_q       <= '0;
            dom_rst_q    <= '1;
            ready_q      <= 1'b0;
            check_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tcnt_q       <= tcnt_d;
            dom_rst_q    <= dom_rst_d;
            ready_q      <= ready_d;
            check_fail_q <= check_fail_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        tcnt_d       = tcnt_q;
        dom_rst_d    = dom_rst_q;
        ready_d      = ready_q;
        check_fail_d = check_fail_q;

        unique case (state_q)
            ST_HOLD: begin
                dom_rst_d = '1;
                ready_d   = 1'b0;
                if (rst_synced_n) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    cnt_d     = '0;
                    dom_rst_d = dom_rst_q & ~(NUM_DOMAINS'(1) << idx_q);
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                        idx_d  = '0;
                        tcnt_d = '0;
                        if (zero_fail_c) begin
                            state_d      = ST_FAIL;
                            dom_rst_d    = '1;
                            check_fail_d = 1'b1;
                        end else begin
                            state_d = ST_CHECK;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_CHECK: begin
                // A match on the timeout cycle still counts as a pass.
                if (result_in == EXPECTED) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    tcnt_d  = '0;
                end else if (tcnt_q == TCNT_W'(CHECK_TIMEOUT - 1)) begin
                    state_d      = ST_FAIL;
                    dom_rst_d    = '1;
                    check_fail_d = 1'b1;
                    tcnt_d       = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            ST_RUN: begin
                ready_d   = 1'b1;
                dom_rst_d = '0;
                if (sw_rst_req) begin
                    state_d   = ST_RELEASE;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                    cnt_d     = '0;
                    idx_d     = '0;
                    tcnt_d    = '0;
                end
            end

            ST_FAIL: begin
                dom_rst_d    = '1;
                ready_d      = 1'b0;
                check_fail_d = 1'b1;
                if (sw_rst_req) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end
            end

            default: begin
                state_d   = ST_HOLD;
                dom_rst_d = '1;
                ready_d   = 1'b0;
                cnt_d     = '0;
                idx_d     = '0;
                tcnt_d    = '0;
            end
        endcase
    end

    assign dom_rst    = dom_rst_q;
    assign ready      = ready_q;
    assign check_fail = check_fail_q;
    assign state_o    = state_q;

endmodule : rst_seq_release

// File: tb/tb_rst_seq_release.sv
// Directed bench for rst_seq_release with default parameters.
module tb_rst_seq_release;

    logic        clk;
    logic        rst_n;
    logic        sw_rst_req;
    logic [23:0] result_in;
    logic [2:0]  dom_rst;
    logic        ready;
    logic        check_fail;
    logic [2:0]  state_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    rst_seq_release dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .result_in  (result_in),
        .dom_rst    (dom_rst),
        .ready      (ready),
        .check_fail (check_fail),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Restart from RUN/FAIL with a one-cycle sw_rst_req; returns on HOLD-exit edge E0.
    task automatic sw_restart();
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        result_in  = 24'h0;
        step(5);
        check_cnt++;
        if ({dom_rst, ready, check_fail, state_o} !== {3'b111, 1'b0, 1'b0, 3'd0})
            $display("FAIL reset_vals got dom=%b rdy=%b cf=%b st=%0d want 111/0/0/0",
                     dom_rst, ready, check_fail, state_o);
        else pass_cnt++;
        rst_n = 1'b1;
        step(2);
        check_cnt++;
        if (state_o !== 3'd0) $display("FAIL sync_hold got st=%0d want 0", state_o);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (state_o !== 3'd1 || dom_rst !== 3'b111)
            $display("FAIL hold_exit got st=%0d dom=%b want 1/111", state_o, dom_rst);
        else pass_cnt++;
    endtask

    // Entered at E0 (HOLD exit); finishes in RUN.
    task automatic test_normal_release();
        step(15);
        check_cnt++;
        if (dom_rst !== 3'b111) $display("FAIL stagger_e15 got %b want 111", dom_rst);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (dom_rst !== 3'b110) $display("FAIL stagger_e16 got %b want 110", dom_rst);
        else pass_cnt++;
        step(16);
        check_cnt++;
        if (dom_rst !== 3'b100) $display("FAIL stagger_e32 got %b want 100", dom_rst);
        else pass_cnt++;
        step(16);
        check_cnt++;
        if (dom_rst !== 3'b000 || state_o !== 3'd2)
            $display("FAIL stagger_e48 got dom=%b st=%0d want 000/2", dom_rst, state_o);
        else pass_cnt++;
        step(2);
        result_in = 24'hC0FFEE;
        step(1);
        check_cnt++;
        if (ready !== 1'b1 || state_o !== 3'd3 || dom_rst !== 3'b000)
            $display("FAIL run_entry got rdy=%b st=%0d dom=%b want 1/3/000",
                     ready, state_o, dom_rst);
        else pass_cnt++;
        result_in = 24'h123456;
        step(3);
        check_cnt++;
        if (ready !== 1'b1 || state_o !== 3'd3)
            $display("FAIL run_no_recheck got rdy=%b st=%0d want 1/3", ready, state_o);
        else pass_cnt++;
    endtask

    // From RUN; result stays zero so CHECK times out.
    task automatic test_timeout();
        result_in = 24'h0;
        sw_restart();
        check_cnt++;
        if (state_o !== 3'd1 || dom_rst !== 3'b111 || ready !== 1'b0 || check_fail !== 1'b0)
            $display("FAIL sw_from_run got st=%0d dom=%b rdy=%b cf=%b want 1/111/0/0",
                     state_o, dom_rst, ready, check_fail);
        else pass_cnt++;
        step(48);
        step(7);
        check_cnt++;
        if (state_o !== 3'd2 || dom_rst !== 3'b000)
            $display("FAIL check_7cyc got st=%0d dom=%b want 2/000", state_o, dom_rst);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if ({state_o, check_fail, dom_rst, ready} !== {3'd4, 1'b1, 3'b111, 1'b0})
            $display("FAIL timeout got st=%0d cf=%b dom=%b rdy=%b want 4/1/111/0",
                     state_o, check_fail, dom_rst, ready);
        else pass_cnt++;
        step(5);
        check_cnt++;
        if (state_o !== 3'd4) $display("FAIL fail_stays got st=%0d want 4", state_o);
        else pass_cnt++;
    endtask

    task automatic test_sw_from_fail();
        sw_restart();
        check_cnt++;
        if (state_o !== 3'd1 || dom_rst !== 3'b111 || check_fail !== 1'b1)
            $display("FAIL sw_from_fail got st=%0d dom=%b cf=%b want 1/111/1",
                     state_o, dom_rst, check_fail);
        else pass_cnt++;
        step(48);
        result_in = 24'hC0FFEE;
        step(1);
        check_cnt++;
        if (ready !== 1'b1 || state_o !== 3'd3 || check_fail !== 1'b1)
            $display("FAIL rerun_pass got rdy=%b st=%0d cf=%b want 1/3/1",
                     ready, state_o, check_fail);
        else pass_cnt++;
    endtask

    // sw_rst_req in RELEASE and in CHECK must not disturb the sequence.
    task automatic test_sw_ignored();
        result_in = 24'h0;
        sw_restart();
        step(5);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(9);
        check_cnt++;
        if (dom_rst !== 3'b111 || state_o !== 3'd1)
            $display("FAIL sw_in_release_e15 got dom=%b st=%0d want 111/1", dom_rst, state_o);
        else pass_cnt++;
        step(1);
        check_cnt++;
        if (dom_rst !== 3'b110) $display("FAIL sw_in_release_e16 got %b want 110", dom_rst);
        else pass_cnt++;
        step(33);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check_cnt++;
        if (state_o !== 3'd2 || dom_rst !== 3'b000)
            $display("FAIL sw_in_check got st=%0d dom=%b want 2/000", state_o, dom_rst);
        else pass_cnt++;
        result_in = 24'hC0FFEE;
        step(1);
        check_cnt++;
        if (ready !== 1'b1 || state_o !== 3'd3)
            $display("FAIL sw_check_done got rdy=%b st=%0d want 1/3", ready, state_o);
        else pass_cnt++;
    endtask

    // rst_n drop between clock edges while dom_rst=100.
    task automatic test_async_abort();
        result_in = 24'h0;
        sw_restart();
        step(32);
        check_cnt++;
        if (dom_rst !== 3'b100) $display("FAIL abort_setup got %b want 100", dom_rst);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({dom_rst, ready, check_fail, state_o} !== {3'b111, 1'b0, 1'b0, 3'd0})
            $display("FAIL async_abort got dom=%b rdy=%b cf=%b st=%0d want 111/0/0/0",
                     dom_rst, ready, check_fail, state_o);
        else pass_cnt++;
    endtask

    // Nonzero result while domain 0 is in reset.
    task automatic test_zero_check();
        step(2);
        result_in = 24'h000001;
        rst_n = 1'b1;
        step(3);
        check_cnt++;
        if (state_o !== 3'd1) $display("FAIL zc_hold_exit got st=%0d want 1", state_o);
        else pass_cnt++;
        step(16);
        result_in = 24'h0;
        step(32);
`ifdef RST_SEQ_ZERO_CHECK_EN
        check_cnt++;
        if ({state_o, check_fail, dom_rst} !== {3'd4, 1'b1, 3'b111})
            $display("FAIL zero_check got st=%0d cf=%b dom=%b want 4/1/111",
                     state_o, check_fail, dom_rst);
        else pass_cnt++;
`else
        check_cnt++;
        if (state_o !== 3'd2 || dom_rst !== 3'b000 || check_fail !== 1'b0)
            $display("FAIL no_zero_check got st=%0d dom=%b cf=%b want 2/000/0",
                     state_o, dom_rst, check_fail);
        else pass_cnt++;
        result_in = 24'hC0FFEE;
        step(1);
        check_cnt++;
        if (ready !== 1'b1 || state_o !== 3'd3 || check_fail !== 1'b0)
            $display("FAIL no_zero_pass got rdy=%b st=%0d cf=%b want 1/3/0",
                     ready, state_o, check_fail);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_normal_release();
        test_timeout();
        test_sw_from_fail();
        test_sw_ignored();
        test_async_abort();
        test_zero_check();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_rst_seq_release
